conv_mac_sequencer: RTL and testbench



---
 rtl/conv_mac_sequencer_if.sv | 31 +++
 rtl/conv_mac_sequencer.sv | 109 ++++++++++
 tb/tb_conv_mac_sequencer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_mac_sequencer_if.sv
// Window-sequencer bus: start/kernel control, index-stage strobe/data and result handshake.
// master = sequencer side, slave = surrounding control / index stage / downstream.
interface conv_mac_sequencer_if #(
  parameter int unsigned MAX_KERNEL = 3,
  parameter int unsigned ACC_W      = 20
);
  localparam int unsigned KS_W  = $clog2(MAX_KERNEL + 1);
  localparam int unsigned IDX_W = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;

  logic                    start;
  logic [KS_W-1:0]         kernel_size;
  logic                    busy;
  logic [IDX_W-1:0]        cur_x;
  logic [IDX_W-1:0]        cur_y;
  logic                    en_strobe;
  logic [7:0]              pixel_v;
  logic [7:0]              kernel_v;
  logic signed [ACC_W-1:0] result;
  logic                    result_valid;
  logic                    result_ready;

  modport master (
    input  start, kernel_size, pixel_v, kernel_v, result_ready,
    output busy, cur_x, cur_y, en_strobe, result, result_valid
  );

  modport slave (
    output start, kernel_size, pixel_v, kernel_v, result_ready,
    input  busy, cur_x, cur_y, en_strobe, result, result_valid
  );
endinterface

// File: rtl/conv_mac_sequencer.sv
// Walks a KxK window through the index stage one element per cycle and
// multiply-accumulates the returned pixel/coefficient pairs into a signed sum.
module conv_mac_sequencer #(
  parameter int unsigned MAX_KERNEL = 3,
  parameter int unsigned ACC_W      = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_mac_sequencer_if.master bus
);
  localparam int unsigned KS_W   = $clog2(MAX_KERNEL + 1);
  localparam int unsigned IDX_W  = (MAX_KERNEL > 1) ? $clog2(MAX_KERNEL) : 1;
  localparam int unsigned PROD_W = 17;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                  state_q;
  logic [IDX_W-1:0]        cur_x_q, cur_y_q, k_last_q;
  logic                    en_strobe_q, strobe_d_q, valid_q, busy_q;
  logic signed [ACC_W-1:0] acc_q;

  logic [IDX_W-1:0]        k_last_c;
  logic signed [PROD_W-1:0] pix_c, coef_c, prod_c;
  logic signed [ACC_W-1:0] prod_ext_c;

  // Clamp requested edge to 1..MAX_KERNEL, stored as K-1
  always_comb begin
    k_last_c = IDX_W'(MAX_KERNEL - 1);
    if (bus.kernel_size == '0) begin
      k_last_c = '0;
    end else if (bus.kernel_size <= KS_W'(MAX_KERNEL)) begin
      k_last_c = IDX_W'(bus.kernel_size - KS_W'(1));
    end
  end

  // Unsigned pixel times signed coefficient always fits in 17 signed bits
  always_comb begin
    pix_c      = {9'b0, bus.pixel_v};
    coef_c     = {{9{bus.kernel_v[7]}}, bus.kernel_v};
    prod_c     = pix_c * coef_c;
    prod_ext_c = {{(ACC_W - PROD_W){prod_c[PROD_W-1]}}, prod_c};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      k_last_q    <= '0;
      en_strobe_q <= 1'b0;
      strobe_d_q  <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      acc_q       <= '0;
    end else begin
      // strobe_d tracks the index stage's one-cycle data register
      strobe_d_q <= en_strobe_q;
      if (strobe_d_q) begin
        acc_q <= acc_q + prod_ext_c;
      end

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            k_last_q    <= k_last_c;
            acc_q       <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            en_strobe_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cur_x_q == k_last_q && cur_y_q == k_last_q) begin
            en_strobe_q <= 1'b0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            state_q     <= DRAIN;
          end else if (cur_x_q == k_last_q) begin
            cur_x_q <= '0;
            cur_y_q <= cur_y_q + IDX_W'(1);
          end else begin
            cur_x_q <= cur_x_q + IDX_W'(1);
          end
        end
        DRAIN: begin
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (bus.result_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cur_x        = cur_x_q;
  assign bus.cur_y        = cur_y_q;
  assign bus.en_strobe    = en_strobe_q;
  assign bus.busy         = busy_q;
  assign bus.result       = acc_q;
  assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Directed bench for conv_mac_sequencer with a behavioural one-cycle index stage;
// a second instance built with MAX_KERNEL=2 covers edge clamping.
module tb_conv_mac_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_mac_sequencer_if #(.MAX_KERNEL(3), .ACC_W(20)) a ();
  conv_mac_sequencer_if #(.MAX_KERNEL(2), .ACC_W(20)) b ();

  conv_mac_sequencer #(.MAX_KERNEL(3), .ACC_W(20)) u_dut   (.clk(clk), .rst(rst), .bus(a));
  conv_mac_sequencer #(.MAX_KERNEL(2), .ACC_W(20)) u_clamp (.clk(clk), .rst(rst), .bus(b));

  logic [7:0] in_mem [3][3];
  logic [7:0] kw_mem [3][3];

  int n_cmp = 0;
  int n_bad = 0;
  int a_n   = 0;
  int b_n   = 0;
  int log_x [$];
  int log_y [$];

  // Index stage model: data registered one cycle after its strobe
  always @(posedge clk) begin
    if (a.en_strobe) begin
      a.pixel_v  <= in_mem[a.cur_x][a.cur_y];
      a.kernel_v <= kw_mem[a.cur_x][a.cur_y];
      a_n <= a_n + 1;
      log_x.push_back(int'(a.cur_x));
      log_y.push_back(int'(a.cur_y));
    end
    if (b.en_strobe) begin
      b.pixel_v  <= in_mem[b.cur_x][b.cur_y];
      b.kernel_v <= kw_mem[b.cur_x][b.cur_y];
      b_n <= b_n + 1;
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  function automatic logic get_valid(input int sel);
    return (sel != 0) ? b.result_valid : a.result_valid;
  endfunction

  function automatic int get_result(input int sel);
    return (sel != 0) ? int'(b.result) : int'(a.result);
  endfunction

  task automatic set_start(input int sel, input logic v, input int k);
    if (sel != 0) begin
      b.start = v; b.kernel_size = 2'(k);
    end else begin
      a.start = v; a.kernel_size = 2'(k);
    end
  endtask

  task automatic set_ready(input int sel, input logic v);
    if (sel != 0) b.result_ready = v;
    else          a.result_ready = v;
  endtask

  task automatic fill(input int pmode, input int kval);
    for (int x = 0; x < 3; x++)
      for (int y = 0; y < 3; y++) begin
        in_mem[x][y] = (pmode < 0) ? 8'(x + 3*y) : 8'(pmode);
        kw_mem[x][y] = 8'(kval);
      end
  endtask

  // Called #1 after an edge; start is sampled by the next edge (cycle 0)
  task automatic run_win(input int sel, input int k, input int exp_sum,
                         input int exp_cyc, input int exp_n, input string tag);
    int base, cyc;
    base = (sel != 0) ? b_n : a_n;
    set_start(sel, 1'b1, k);
    @(posedge clk); #1;
    set_start(sel, 1'b0, k);
    cyc = 0;
    while (!get_valid(sel) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, cyc + 1, exp_cyc);
    check({tag, "_sum"}, get_result(sel), exp_sum);
    check({tag, "_nstrobe"}, ((sel != 0) ? b_n : a_n) - base, exp_n);
    set_ready(sel, 1'b1);
    @(posedge clk); #1;
    set_ready(sel, 1'b0);
    check({tag, "_valid_drop"}, get_valid(sel), 0);
  endtask

  initial begin
    int base, cyc, maxc, seen;
    a.start = 0; a.kernel_size = 0; a.result_ready = 0; a.pixel_v = 0; a.kernel_v = 0;
    b.start = 0; b.kernel_size = 0; b.result_ready = 0; b.pixel_v = 0; b.kernel_v = 0;
    fill(-1, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", a.busy, 0);
    check("rst_valid", a.result_valid, 0);
    check("rst_strobe", a.en_strobe, 0);
    check("rst_result", a.result, 0);
    check("rst_cur", {a.cur_x, a.cur_y}, 0);
    rst = 0;
    @(posedge clk); #1;

    // Ramp image, unit kernel: 0+1+...+8 = 36, strobe order x-inner
    base = log_x.size();
    run_win(0, 3, 36, 11, 9, "ramp3");
    for (int i = 0; i < 9; i++) begin
      check("order_x", log_x[base+i], i % 3);
      check("order_y", log_y[base+i], i / 3);
    end

    // Edge detector columns: -1 on x=0, +1 on x=2
    for (int x = 0; x < 3; x++)
      for (int y = 0; y < 3; y++) begin
        in_mem[x][y] = 8'd200;
        kw_mem[x][y] = (x == 0) ? 8'hFF : ((x == 2) ? 8'h01 : 8'h00);
      end
    run_win(0, 3, 0, 11, 9, "edge_flat");
    for (int y = 0; y < 3; y++) in_mem[2][y] = 8'd50;
    run_win(0, 3, -450, 11, 9, "edge_step");

    fill(255, -128);
    run_win(0, 3, -293760, 11, 9, "ext_neg");
    fill(255, 127);
    run_win(0, 3, 291465, 11, 9, "ext_pos");

    // K=2 on ramp: 0+1+3+4
    fill(-1, 1);
    base = log_x.size();
    run_win(0, 2, 8, 6, 4, "k2");
    maxc = 0;
    for (int i = base; i < log_x.size(); i++) begin
      if (log_x[i] > maxc) maxc = log_x[i];
      if (log_y[i] > maxc) maxc = log_y[i];
    end
    check("k2_maxcur", maxc, 1);

    // K=0 clamps to a single element
    in_mem[0][0] = 8'd7; kw_mem[0][0] = 8'hFB;
    run_win(0, 0, -35, 3, 1, "k0");

    // MAX_KERNEL=2 build clamps K=3 down to 2
    fill(-1, 1);
    run_win(1, 3, 8, 6, 4, "clamp");

    // Backpressure: hold ready low in DONE while pulsing start
    set_start(0, 1'b1, 3);
    @(posedge clk); #1;
    set_start(0, 1'b0, 3);
    cyc = 0;
    while (!a.result_valid && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    check("bp_lat", cyc + 1, 11);
    base = a_n;
    for (int i = 0; i < 5; i++) begin
      a.start = ~a.start;
      @(posedge clk); #1;
      check("bp_valid", a.result_valid, 1);
      check("bp_result", a.result, 36);
    end
    a.start = 0;
    check("bp_nostrobe", a_n - base, 0);
    a.result_ready = 1;
    @(posedge clk); #1;
    a.result_ready = 0;
    check("bp_idle_valid", a.result_valid, 0);
    check("bp_idle_busy", a.busy, 0);
    a.start = 1; a.kernel_size = 2'd3;
    @(posedge clk); #1;
    a.start = 0;
    check("bp_restart_busy", a.busy, 1);
    check("bp_restart_strobe", a.en_strobe, 1);
    cyc = 0;
    while (!a.result_valid && cyc < 60) begin
      @(posedge clk); #1; cyc++;
    end
    check("bp_restart_sum", a.result, 36);
    a.result_ready = 1;
    @(posedge clk); #1;
    a.result_ready = 0;

    // Reset during the fourth strobe cycle aborts the window
    a.start = 1; a.kernel_size = 2'd3;
    @(posedge clk); #1;
    a.start = 0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("abort_busy", a.busy, 0);
    check("abort_strobe", a.en_strobe, 0);
    check("abort_cur", {a.cur_x, a.cur_y}, 0);
    check("abort_result", a.result, 0);
    check("abort_valid", a.result_valid, 0);
    seen = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (a.result_valid) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    run_win(0, 3, 36, 11, 9, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
